// File: rtl/ripple_carry_adder_2_stage.sv
// Two-stage pipelined ripple-carry adder: {cout,sum} = a + b + cin.
// The lower half is added in stage 1 and the upper half in stage 2, joined by a registered carry.

module RcaFullAdder (
    input  logic i_x,
    input  logic i_y,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_x ^ i_y ^ i_c;
    assign o_co = (i_x & i_y) | (i_c & (i_x ^ i_y));

endmodule

module ripple_carry_adder_2_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    logic [LO_W-1:0]  r_s1Lo;
    logic             r_s1C;
    logic [HI_W-1:0]  r_s1AHi;
    logic [HI_W-1:0]  r_s1BHi;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [LO_W:0]    w_loCarry;
    logic [LO_W-1:0]  w_loSum;
    logic [HI_W:0]    w_hiCarry;
    logic [HI_W-1:0]  w_hiSum;

    assign w_loCarry[0] = cin;
    assign w_hiCarry[0] = r_s1C;

    for (genvar g = 0; g < LO_W; g++) begin : g_loChain
        RcaFullAdder uLoFa (
            .i_x  (a[g]),
            .i_y  (b[g]),
            .i_c  (w_loCarry[g]),
            .o_s  (w_loSum[g]),
            .o_co (w_loCarry[g+1])
        );
    end

    // The upper chain works on the operands captured alongside r_s1C, so its carry-in
    // always belongs to the same operand set.
    for (genvar g = 0; g < HI_W; g++) begin : g_hiChain
        RcaFullAdder uHiFa (
            .i_x  (r_s1AHi[g]),
            .i_y  (r_s1BHi[g]),
            .i_c  (w_hiCarry[g]),
            .o_s  (w_hiSum[g]),
            .o_co (w_hiCarry[g+1])
        );
    end

    // Stage 1: lower sum, lower carry, and the untouched upper operand halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Lo  <= '0;
            r_s1C   <= 1'b0;
            r_s1AHi <= '0;
            r_s1BHi <= '0;
        end else begin
            r_s1Lo  <= w_loSum;
            r_s1C   <= w_loCarry[LO_W];
            r_s1AHi <= a[WIDTH-1:LO_W];
            r_s1BHi <= b[WIDTH-1:LO_W];
        end
    end

    // Stage 2: merge the upper sum with the lower slice carried over from stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= {w_hiSum, r_s1Lo};
            r_cout <= w_hiCarry[HI_W];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_ripple_carry_adder_2_stage.sv
// Directed and random checks of the 2-stage adder at WIDTH 4, 8 and 5.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_ripple_carry_adder_2_stage;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] expSum;
        logic       expCout;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] a4, b4, sum4;
    logic       cin4, cout4;
    logic [7:0] a8, b8, sum8;
    logic       cin8, cout8;
    logic [4:0] a5, b5, sum5;
    logic       cin5, cout5;

    int vectorCount;
    int failCount;

    ripple_carry_adder_2_stage #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .sum(sum4), .cout(cout4)
    );
    ripple_carry_adder_2_stage #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8)
    );
    ripple_carry_adder_2_stage #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .a(a5), .b(b5), .cin(cin5), .sum(sum5), .cout(cout5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actSum, input logic actCout,
                               input logic [7:0] expSum, input logic expCout);
        vectorCount++;
        if (actSum !== expSum || actCout !== expCout) begin
            failCount++;
            $display("[TB] FAIL %s: got sum=%0d cout=%0d, expected sum=%0d cout=%0d",
                     name, actSum, actCout, expSum, expCout);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic cin);
        a4   = a;
        b4   = b;
        cin4 = cin;
    endtask

    initial begin
        vec_t vecs[9];
        logic [8:0] q8[$];
        logic [5:0] q5[$];
        logic [4:0] q4[$];

        vecs[0] = '{a: 4'd0,  b: 4'd0,  cin: 1'b0, expSum: 4'd0,  expCout: 1'b0};
        vecs[1] = '{a: 4'd1,  b: 4'd1,  cin: 1'b1, expSum: 4'd3,  expCout: 1'b0};
        vecs[2] = '{a: 4'd11, b: 4'd1,  cin: 1'b1, expSum: 4'd13, expCout: 1'b0};
        vecs[3] = '{a: 4'd14, b: 4'd5,  cin: 1'b1, expSum: 4'd4,  expCout: 1'b1};
        vecs[4] = '{a: 4'd14, b: 4'd5,  cin: 1'b0, expSum: 4'd3,  expCout: 1'b1};
        vecs[5] = '{a: 4'd15, b: 4'd15, cin: 1'b1, expSum: 4'd15, expCout: 1'b1};
        vecs[6] = '{a: 4'd15, b: 4'd0,  cin: 1'b1, expSum: 4'd0,  expCout: 1'b1};
        vecs[7] = '{a: 4'd7,  b: 4'd8,  cin: 1'b0, expSum: 4'd15, expCout: 1'b0};
        vecs[8] = '{a: 4'd5,  b: 4'd10, cin: 1'b1, expSum: 4'd0,  expCout: 1'b1};

        vectorCount = 0;
        failCount   = 0;
        rst  = 1'b1;
        applyStimulus(4'd9, 4'd9, 1'b1);
        a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
        a5 = 5'd0; b5 = 5'd0; cin5 = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("resetHeld", 8'(sum4), cout4, 8'd0, 1'b0);
        rst = 1'b0;

        // Back-to-back table stream: vector i is checked two falling edges after it is driven.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i >= 2)
                checkOutput($sformatf("vec%0d", i - 2), 8'(sum4), cout4,
                            8'(vecs[i-2].expSum), vecs[i-2].expCout);
            if (i < 9)
                applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
        end

        // Fill the pipeline with nonzero data, then hit reset mid-cycle.
        applyStimulus(4'd15, 4'd15, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("preReset", 8'(sum4), cout4, 8'd15, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("asyncReset", 8'(sum4), cout4, 8'd0, 1'b0);
        applyStimulus(4'd3, 4'd4, 1'b0);
        @(negedge clk);
        checkOutput("resetHold", 8'(sum4), cout4, 8'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postRelease1", 8'(sum4), cout4, 8'd0, 1'b0);
        @(negedge clk);
        checkOutput("postRelease2", 8'(sum4), cout4, 8'd7, 1'b0);

        // Continuous random stream on all three widths against a+b+cin delayed two cycles.
        for (int k = 0; k < 1002; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                logic [4:0] e4;
                logic [8:0] e8;
                logic [5:0] e5;
                e4 = q4.pop_front();
                e8 = q8.pop_front();
                e5 = q5.pop_front();
                checkOutput("rand4", 8'(sum4), cout4, 8'(e4[3:0]), e4[4]);
                checkOutput("rand8", sum8, cout8, e8[7:0], e8[8]);
                checkOutput("rand5", 8'(sum5), cout5, 8'(e5[4:0]), e5[5]);
            end
            if (k < 1000) begin
                applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
                a8 = 8'($urandom_range(255)); b8 = 8'($urandom_range(255)); cin8 = 1'($urandom_range(1));
                a5 = 5'($urandom_range(31));  b5 = 5'($urandom_range(31));  cin5 = 1'($urandom_range(1));
                q4.push_back(5'(a4) + 5'(b4) + 5'(cin4));
                q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
                q5.push_back(6'(a5) + 6'(b5) + 6'(cin5));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
